// File: rtl/fb_px_arbiter.sv
// Round-robin sharing of the frame-buffer pixel port between the CPU (port 0) and the
// fill/blit engine (port 1), driving the 4-phase request/ready handshake to the pixel domain.
module fb_px_arbiter #(
   parameter int TIMEOUT_CYCLES = 1023,
   parameter int SYNC_STAGES    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        r0_req,
   input  logic        r0_write,
   input  logic [15:0] r0_addr,
   input  logic [23:0] r0_wdata,
   output logic        r0_ack,
   output logic        r0_done,
   output logic [23:0] r0_rdata,
   input  logic        r1_req,
   input  logic        r1_write,
   input  logic [15:0] r1_addr,
   input  logic [23:0] r1_wdata,
   output logic        r1_ack,
   output logic        r1_done,
   output logic [23:0] r1_rdata,
   output logic        err,
   output logic        fb_px_request_a,
   output logic        fb_px_write,
   output logic [15:0] fb_px_address,
   output logic [23:0] fb_px_write_data,
   input  logic        fb_px_ready,
   input  logic [23:0] fb_px_read_data
);
   localparam int CNT_W = 10;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, REQ, REL, DONE} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] rdy_sync;
   logic                   rdy_s;
   logic                   pick1, grant, cnt_hit, tmo_set, rd_update;
   logic [CNT_W-1:0]       cnt_q;
   logic                   tmo_q, gnt_q, last_grant_q;
   logic [23:0]            hold_q, rd_value;

   assign rdy_s     = rdy_sync[SYNC_STAGES-1];
   // On a tie the port that did not win last time is served.
   assign pick1     = r1_req & (~r0_req | ~last_grant_q);
   assign grant     = (state_q == IDLE) & (r0_req | r1_req);
   assign cnt_hit   = (cnt_q == CNT_LAST);
   assign tmo_set   = cnt_hit & (((state_q == REQ) & ~rdy_s) | ((state_q == REL) & rdy_s));
   assign rd_update = (state_q == REL) & (state_d == DONE) & ~fb_px_write;
   assign rd_value  = (tmo_q | tmo_set) ? 24'd0 : hold_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rdy_sync <= '0;
      else       rdy_sync <= {rdy_sync[SYNC_STAGES-2:0], fb_px_ready};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (r0_req | r1_req) state_d = REQ;
         REQ:     if (rdy_s | cnt_hit) state_d = REL;
         REL:     if (~rdy_s | cnt_hit) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      r0_done = 1'b0;
      r1_done = 1'b0;
      err     = 1'b0;
      if (state_q == DONE) begin
         r0_done = ~gnt_q;
         r1_done = gnt_q;
         err     = tmo_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q           <= '0;
         tmo_q           <= 1'b0;
         gnt_q           <= 1'b0;
         last_grant_q    <= 1'b1;
         r0_ack          <= 1'b0;
         r1_ack          <= 1'b0;
         fb_px_request_a <= 1'b0;
         fb_px_write     <= 1'b0;
         fb_px_address   <= '0;
         fb_px_write_data <= '0;
         r0_rdata        <= '0;
         r1_rdata        <= '0;
      end else begin
         r0_ack          <= grant & ~pick1;
         r1_ack          <= grant & pick1;
         fb_px_request_a <= (state_d == REQ);
         // Each handshake phase gets its own timeout window.
         if (state_d != state_q)
            cnt_q <= '0;
         else if ((state_q == REQ) || (state_q == REL))
            cnt_q <= cnt_q + 1'b1;
         if (state_q == DONE)
            tmo_q <= 1'b0;
         else if (tmo_set)
            tmo_q <= 1'b1;
         if (grant) begin
            gnt_q            <= pick1;
            last_grant_q     <= pick1;
            fb_px_write      <= pick1 ? r1_write : r0_write;
            fb_px_address    <= pick1 ? r1_addr : r0_addr;
            fb_px_write_data <= pick1 ? r1_wdata : r0_wdata;
         end
         if (rd_update && !gnt_q) r0_rdata <= rd_value;
         if (rd_update && gnt_q)  r1_rdata <= rd_value;
      end
   end

   // Read data is only guaranteed stable while the synchronised ready is high.
   always_ff @(posedge clk) begin
      if ((state_q == REQ) && rdy_s && !fb_px_write)
         hold_q <= fb_px_read_data;
   end
endmodule

// File: tb/tb_fb_px_arbiter.sv
// Directed bench for fb_px_arbiter with a small frame-buffer ready model.
module tb_fb_px_arbiter;
   localparam int TO = 16;

   logic        clk = 1'b0, reset = 1'b1;
   logic        r0_req = 0, r0_write = 0, r1_req = 0, r1_write = 0;
   logic [15:0] r0_addr = '0, r1_addr = '0;
   logic [23:0] r0_wdata = '0, r1_wdata = '0;
   logic        r0_ack, r0_done, r1_ack, r1_done, err;
   logic [23:0] r0_rdata, r1_rdata;
   logic        fb_px_request_a, fb_px_write, fb_px_ready;
   logic [15:0] fb_px_address;
   logic [23:0] fb_px_write_data, fb_px_read_data;

   int          n_chk = 0, n_pass = 0, cyc = 0;
   int          n_done0 = 0, n_done1 = 0, n_err = 0;
   int          fb_mode = 0;
   logic        man_rdy = 1'b0;
   logic [23:0] fb_rd_val = '0;
   logic [2:0]  rq_hist = '0;

   int          ack_p[4], ack_c[4], done_c[4];

   fb_px_arbiter #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset),
      .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_ack(r0_ack), .r0_done(r0_done), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_ack(r1_ack), .r1_done(r1_done), .r1_rdata(r1_rdata),
      .err(err),
      .fb_px_request_a(fb_px_request_a), .fb_px_write(fb_px_write),
      .fb_px_address(fb_px_address), .fb_px_write_data(fb_px_write_data),
      .fb_px_ready(fb_px_ready), .fb_px_read_data(fb_px_read_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rq_hist <= {rq_hist[1:0], fb_px_request_a};
   end

   // Modes: 0 ideal, 1 ready follows request by 3 clk, 2 never ready, 3 manual.
   always_comb begin
      case (fb_mode)
         0:       fb_px_ready = fb_px_request_a;
         1:       fb_px_ready = rq_hist[2];
         2:       fb_px_ready = 1'b0;
         default: fb_px_ready = man_rdy;
      endcase
   end
   assign fb_px_read_data = fb_rd_val;

   always @(negedge clk) begin
      if (r0_done) n_done0 <= n_done0 + 1;
      if (r1_done) n_done1 <= n_done1 + 1;
      if (err)     n_err   <= n_err + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic run_txn(input bit port, input logic wr, input logic [15:0] a, input logic [23:0] d,
                          output int ack_cy, output int fall_cy, output int done_cy,
                          output logic [23:0] rd, output logic e, output logic [15:0] a_seen,
                          output logic w_seen, output logic [23:0] d_seen);
      int   k;
      logic prev;
      @(negedge clk);
      if (port) begin r1_req = 1; r1_write = wr; r1_addr = a; r1_wdata = d; end
      else      begin r0_req = 1; r0_write = wr; r0_addr = a; r0_wdata = d; end
      k = 0;
      do begin @(negedge clk); k++; end while (!(port ? r1_ack : r0_ack) && k < 50);
      check("ack_seen", {31'd0, (port ? r1_ack : r0_ack)}, 1);
      ack_cy = cyc;
      r0_req = 0; r1_req = 0;
      a_seen = fb_px_address; w_seen = fb_px_write; d_seen = fb_px_write_data;
      prev = fb_px_request_a;
      fall_cy = -1;
      k = 0;
      do begin
         @(negedge clk); k++;
         if (prev && !fb_px_request_a) fall_cy = cyc;
         prev = fb_px_request_a;
      end while (!(port ? r1_done : r0_done) && k < 200);
      check("done_seen", {31'd0, (port ? r1_done : r0_done)}, 1);
      done_cy = cyc;
      rd = port ? r1_rdata : r0_rdata;
      e  = err;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          ac, fc, dc, k, nack, ndone, nd, rc;
      logic [23:0] rd, ds;
      logic [15:0] as;
      logic        e, ws, prev;

      repeat (3) @(negedge clk);
      check("rst_request", {31'd0, fb_px_request_a}, 0);
      check("rst_ack0", {31'd0, r0_ack}, 0);
      check("rst_done1", {31'd0, r1_done}, 0);
      check("rst_err", {31'd0, err}, 0);
      check("rst_addr", {16'd0, fb_px_address}, 0);
      check("rst_rdata0", {8'd0, r0_rdata}, 0);
      reset = 0;
      repeat (2) @(negedge clk);

      // Single write on port 0 with 3-cycle FB latency.
      fb_mode = 1;
      run_txn(0, 1, 16'h1234, 24'hA5B6C7, ac, fc, dc, rd, e, as, ws, ds);
      check("t1_addr", {16'd0, as}, 32'h1234);
      check("t1_write", {31'd0, ws}, 1);
      check("t1_wdata", {8'd0, ds}, 32'hA5B6C7);
      check("t1_err", {31'd0, e}, 0);
      check("t1_fall", fc - ac, 6);
      check("t1_lat", dc - ac, 12);
      repeat (3) @(negedge clk);
      check("t1_ndone0", n_done0, 1);
      check("t1_ndone1", n_done1, 0);
      check("t1_addr_hold", {16'd0, fb_px_address}, 32'h1234);

      // Single read on port 1.
      fb_rd_val = 24'h123456;
      run_txn(1, 0, 16'h00FF, 24'h0, ac, fc, dc, rd, e, as, ws, ds);
      check("t2_rdata1", {8'd0, rd}, 32'h123456);
      check("t2_err", {31'd0, e}, 0);
      check("t2_addr", {16'd0, as}, 32'h00FF);
      check("t2_write", {31'd0, ws}, 0);
      check("t2_rdata0", {8'd0, r0_rdata}, 0);
      repeat (3) @(negedge clk);
      check("t2_ndone1", n_done1, 1);

      // Both ports requesting continuously, ideal FB.
      fb_mode = 0;
      for (int i = 0; i < 4; i++) begin ack_p[i] = -1; ack_c[i] = 0; done_c[i] = 0; end
      @(negedge clk);
      r0_write = 1; r0_addr = 16'h0A0A; r1_write = 0; r1_addr = 16'h0B0B;
      r0_req = 1; r1_req = 1;
      nack = 0; ndone = 0;
      for (int j = 0; j < 200 && ndone < 4; j++) begin
         @(negedge clk);
         if (r0_ack || r1_ack) begin
            if (nack < 4) begin ack_p[nack] = r1_ack ? 1 : 0; ack_c[nack] = cyc; end
            nack++;
         end
         if (r0_done || r1_done) begin
            if (ndone < 4) done_c[ndone] = cyc;
            ndone++;
         end
      end
      r0_req = 0; r1_req = 0;
      check("t3_ndone", ndone, 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t3_port%0d", i), ack_p[i], i % 2);
         check($sformatf("t3_lat%0d", i), done_c[i] - ack_c[i], 6);
      end
      for (int i = 0; i < 3; i++)
         check($sformatf("t3_gap%0d", i), ack_c[i+1] - done_c[i], 2);
      repeat (3) @(negedge clk);

      // Read on port 0, then a read that times out, then a normal transaction.
      fb_mode = 1; fb_rd_val = 24'h0F0F0F;
      run_txn(0, 0, 16'h0C0C, 24'h0, ac, fc, dc, rd, e, as, ws, ds);
      check("t4_rd_ok", {8'd0, rd}, 32'h0F0F0F);
      fb_mode = 2;
      run_txn(0, 0, 16'h0BAD, 24'h0, ac, fc, dc, rd, e, as, ws, ds);
      check("t4_tmo_fall", fc - ac, TO);
      check("t4_tmo_lat", dc - ac, TO + 1);
      check("t4_tmo_err", {31'd0, e}, 1);
      check("t4_tmo_rdata", {8'd0, rd}, 0);
      fb_mode = 0;
      run_txn(1, 1, 16'h0777, 24'h777777, ac, fc, dc, rd, e, as, ws, ds);
      check("t4_next_err", {31'd0, e}, 0);
      check("t4_next_lat", dc - ac, 6);
      repeat (3) @(negedge clk);
      check("t4_nerr", n_err, 1);

      // Asynchronous reset while the request is outstanding.
      fb_mode = 2;
      @(negedge clk);
      r0_write = 1; r0_addr = 16'h3333; r0_wdata = 24'h333333; r0_req = 1;
      k = 0;
      do begin @(negedge clk); k++; end while (!r0_ack && k < 50);
      check("t5_ack", {31'd0, r0_ack}, 1);
      r0_req = 0;
      repeat (3) @(negedge clk);
      check("t5_req_high", {31'd0, fb_px_request_a}, 1);
      #2 reset = 1;
      #1;
      check("t5_req_async", {31'd0, fb_px_request_a}, 0);
      check("t5_addr_rst", {16'd0, fb_px_address}, 0);
      nd = 0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         if (j == 3) reset = 0;
         if (r0_done || r1_done) nd++;
      end
      check("t5_no_done", nd, 0);
      fb_mode = 1;
      run_txn(0, 1, 16'h4321, 24'hBEEF01, ac, fc, dc, rd, e, as, ws, ds);
      check("t5_post_addr", {16'd0, as}, 32'h4321);
      check("t5_post_err", {31'd0, e}, 0);
      check("t5_post_lat", dc - ac, 12);
      repeat (3) @(negedge clk);

      // Ready rises right after request and is held well past release.
      fb_mode = 3; man_rdy = 0;
      @(negedge clk);
      r1_write = 1; r1_addr = 16'h5555; r1_wdata = 24'h555555; r1_req = 1;
      k = 0;
      do begin @(negedge clk); k++; end while (!r1_ack && k < 50);
      check("t6_ack", {31'd0, r1_ack}, 1);
      ac = cyc; r1_req = 0; man_rdy = 1;
      prev = 1'b1; fc = -1; rc = -1; dc = -1; nd = 0; e = 1'b1;
      for (int j = 0; j < 60; j++) begin
         @(negedge clk);
         if (prev && !fb_px_request_a) fc = cyc;
         prev = fb_px_request_a;
         if (r0_done || r1_done) begin nd++; dc = cyc; e = err; end
         if (fc >= 0 && rc < 0 && cyc == fc + 8) begin man_rdy = 0; rc = cyc; end
      end
      check("t6_fall", fc - ac, 3);
      check("t6_ndone", nd, 1);
      check("t6_done_after_low", dc - rc, 3);
      check("t6_err", {31'd0, e}, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
